// File: rtl/lsq_drain_unit_pkg.sv
// Shared types, size encodings and lane helpers for the LSQ drain unit.
`ifndef LSQ_SIZE
`define LSQ_SIZE 8
`endif

package lsq_drain_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic              valid;
    logic              store;
    logic              ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    int                tag;
    logic [1:0]        size;
    logic              unsigned_ld;
  } lsq_entry;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQ        = 3'd1,
    ST_WAIT       = 3'd2,
    ST_DONE       = 3'd3,
    ST_FLUSH_WAIT = 3'd4
  } lsq_drain_state_t;

  // Byte-lane enables for a naturally aligned access of the given size.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << lane;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsq_drain_unit_load_align.sv
// Load data aligner: selects the addressed lane of a memory word and
// zero- or sign-extends it to the access size. Shared with store forwarding.
module load_align
  import lsq_drain_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  // Bring the addressed byte to bit 0, then trim and extend to the access size.
  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (size)
      SZ_BYTE: begin
        if (unsigned_ld) begin
          data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
        end else begin
          data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
        end
      end
      SZ_HALF: begin
        if (unsigned_ld) begin
          data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
        end else begin
          data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
        end
      end
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsq_drain_unit.sv
// Drains the LSQ head one entry at a time into the data-memory port and
// returns aligned load data to the result bus.
module lsq_drain_unit
  import lsq_drain_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  lsq_entry          lsq [`LSQ_SIZE],
  input  int                lsq_head,
  input  int                lsq_count,
  input  logic              rob_commit_valid,
  input  int                rob_commit_tag,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              lsq_decrement,
  output logic              load_result_valid,
  output int                load_result_tag,
  output logic [DATA_W-1:0] load_result_data,
  output logic              busy
);

  lsq_drain_state_t  state_r, state_nxt_s;
  lsq_entry          head_s;
  logic              head_eligible_s;
  logic              latch_head_s;
  logic              capture_load_s;
  logic [DATA_W-1:0] aligned_s;

  int                tag_r;
  logic              store_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic [DATA_W-1:0] data_r;
  logic              unsigned_r;
  int                result_tag_r;
  logic [DATA_W-1:0] result_data_r;

  // Head entry select; an out-of-range head yields an all-zero (invalid) entry.
  always_comb begin
    head_s = '0;
    for (int i = 0; i < `LSQ_SIZE; i++) begin
      if (lsq_head == i + 32'sd1) begin
        head_s = lsq[i];
      end else begin
        head_s = head_s;
      end
    end
  end

  // A store may only leave once the ROB commits exactly its tag.
  always_comb begin
    head_eligible_s = (lsq_count > 32'sd0) && head_s.valid && head_s.ready && !flush &&
                      (!head_s.store || (rob_commit_valid && (rob_commit_tag == head_s.tag)));
  end

  // Next-state selection plus the strobes that load holding and result registers.
  always_comb begin
    state_nxt_s    = state_r;
    latch_head_s   = 1'b0;
    capture_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (head_eligible_s) begin
          latch_head_s = 1'b1;
          state_nxt_s  = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A granted load that is flushed still owes us a response.
        if (dmem_gnt) begin
          state_nxt_s = (flush && !store_r) ? ST_FLUSH_WAIT : ST_WAIT;
        end else if (flush && !store_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          if (flush && !store_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s    = ST_DONE;
            capture_load_s = !store_r;
          end
        end else if (flush && !store_r) begin
          state_nxt_s = ST_FLUSH_WAIT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_FLUSH_WAIT: begin
        if (dmem_rvalid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FLUSH_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Holding registers keep the request stable while the head may change underneath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_r      <= 32'sd0;
      store_r    <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      size_r     <= 2'd0;
      data_r     <= {DATA_W{1'b0}};
      unsigned_r <= 1'b0;
    end else if (latch_head_s) begin
      tag_r      <= head_s.tag;
      store_r    <= head_s.store;
      addr_r     <= head_s.address;
      size_r     <= head_s.size;
      data_r     <= head_s.data;
      unsigned_r <= head_s.unsigned_ld;
    end
  end

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .lane        (addr_r[1:0]),
    .size        (size_r),
    .unsigned_ld (unsigned_r),
    .data        (aligned_s)
  );

  // Load result is registered on the response so it is valid alongside DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_tag_r  <= 32'sd0;
      result_data_r <= {DATA_W{1'b0}};
    end else if (capture_load_s) begin
      result_tag_r  <= tag_r;
      result_data_r <= aligned_s;
    end
  end

  // Memory request and retire strobes decoded from state and holding registers.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = {ADDR_W{1'b0}};
    dmem_wdata = {DATA_W{1'b0}};
    dmem_be    = 4'b0000;
    if (state_r == ST_REQ) begin
      dmem_req   = 1'b1;
      dmem_we    = store_r;
      dmem_addr  = addr_r;
      dmem_be    = byte_enables(size_r, addr_r[1:0]);
      dmem_wdata = store_r ? (data_r << {addr_r[1:0], 3'b000}) : {DATA_W{1'b0}};
    end else begin
      dmem_req = 1'b0;
    end
    lsq_decrement     = (state_r == ST_DONE);
    load_result_valid = (state_r == ST_DONE) && !store_r;
    busy              = (state_r != ST_IDLE);
  end

  assign load_result_tag  = result_tag_r;
  assign load_result_data = result_data_r;

endmodule

// File: tb/tb_lsq_drain_unit.sv
// Self-checking bench for lsq_drain_unit: directed vector table, hand-built
// corner sequences and randomized transactions against an arithmetic model.
module tb_lsq_drain_unit;
  import lsq_drain_unit_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  lsq_entry          lsq [`LSQ_SIZE];
  int                lsq_head, lsq_count, rob_commit_tag;
  logic              rob_commit_valid, flush;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_gnt, dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              lsq_decrement, load_result_valid, busy;
  int                load_result_tag;
  logic [DATA_W-1:0] load_result_data;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int dec_count = 0;
  int res_count = 0;
  int exp_decs = 0;

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    int          tag;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] res;
  } vec_t;

  lsq_drain_unit dut (
    .clk(clk), .reset(reset), .lsq(lsq), .lsq_head(lsq_head), .lsq_count(lsq_count),
    .rob_commit_valid(rob_commit_valid), .rob_commit_tag(rob_commit_tag), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .lsq_decrement(lsq_decrement), .load_result_valid(load_result_valid),
    .load_result_tag(load_result_tag), .load_result_data(load_result_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lsq_decrement) dec_count++;
    if (load_result_valid) res_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream bookkeeping reacting to a retire pulse.
  task automatic retire();
    lsq[lsq_head-1].valid = 1'b0;
    lsq_count = lsq_count - 1;
    lsq_head = (lsq_head == `LSQ_SIZE) ? 1 : lsq_head + 1;
    exp_decs++;
  endtask

  function automatic logic [3:0] ref_be(input int size, input int lane);
    int nbytes;
    nbytes = 1 << size;
    return 4'(((1 << nbytes) - 1) << lane);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] data, input int lane);
    longint v;
    v = longint'(data) * (64'sd1 << (8 * lane));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int lane, input int size, input logic uns);
    longint span, v;
    span = 64'sd1 << (8 << size);
    v = (longint'(rdata) / (64'sd1 << (8 * lane))) % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // One full transaction for entry e at the current head, with the given grant and response delays.
  task automatic do_txn(input lsq_entry e, input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                        output int done_cyc);
    lsq[lsq_head-1] = e;
    if (lsq_count == 0) lsq_count = 1;
    if (e.store) begin
      rob_commit_valid = 1'b1;
      rob_commit_tag = e.tag + 1;
      step();
      step();
      chk("store_waits_commit", dmem_req, 1'b0);
      rob_commit_tag = e.tag;
    end
    step();
    chk("req_latency", dmem_req, 1'b1);
    rob_commit_valid = 1'b0;
    chk("req_we", dmem_we, e.store);
    chk("req_addr", dmem_addr, e.address);
    chk("req_be", dmem_be, exp_be);
    chk("req_wdata", dmem_wdata, exp_wdata);
    for (int i = 0; i < gnt_dly; i++) begin
      step();
      chk("stall_req", dmem_req, 1'b1);
      chk("stall_addr", dmem_addr, e.address);
      chk("stall_be", dmem_be, exp_be);
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("wait_req_low_busy", {dmem_req, busy}, 2'b01);
    for (int i = 0; i < rv_dly; i++) begin
      step();
      chk("wait_no_dec", lsq_decrement, 1'b0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = rdata;
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata = $urandom;
    done_cyc = cyc;
    chk("done_dec", lsq_decrement, 1'b1);
    chk("done_result_valid", load_result_valid, !e.store);
    if (!e.store) begin
      chk("done_result_tag", load_result_tag, e.tag);
      chk("done_result_data", load_result_data, exp_res);
    end
    retire();
    step();
    chk("after_done_idle", {lsq_decrement, load_result_valid, busy}, 3'b000);
  endtask

  initial begin
    vec_t        vecs [8];
    lsq_entry    e;
    int          t0, t1, t2, dec0, res0, sz, lane;
    logic [31:0] rd;

    reset = 1'b0; flush = 1'b0; rob_commit_valid = 1'b0; rob_commit_tag = 0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0; lsq_head = 1; lsq_count = 0;
    for (int i = 0; i < `LSQ_SIZE; i++) lsq[i] = '0;

    //          st    size  uns   addr          data          tag  rdata         gd rd be       wdata         res
    vecs[0] = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h00000000, 5,  32'hDEADBEEF, 0, 0, 4'b1111, 32'h00000000, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'd0, 1'b0, 32'h00000103, 32'h00000000, 6,  32'h80123456, 0, 0, 4'b1000, 32'h00000000, 32'hFFFFFF80};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 32'h00000103, 32'h00000000, 9,  32'h80123456, 0, 1, 4'b1000, 32'h00000000, 32'h00000080};
    vecs[3] = '{1'b1, 2'd1, 1'b0, 32'h00000202, 32'h00001234, 7,  32'h00000000, 0, 0, 4'b1100, 32'h12340000, 32'h00000000};
    vecs[4] = '{1'b0, 2'd2, 1'b0, 32'h00000300, 32'h00000000, 11, 32'hCAFEF00D, 3, 0, 4'b1111, 32'h00000000, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 2'd1, 1'b0, 32'h00000102, 32'h00000000, 12, 32'hBEEF0000, 1, 2, 4'b1100, 32'h00000000, 32'hFFFFBEEF};
    vecs[6] = '{1'b1, 2'd0, 1'b0, 32'h00000101, 32'h000000AB, 13, 32'h00000000, 2, 1, 4'b0010, 32'h0000AB00, 32'h00000000};
    vecs[7] = '{1'b0, 2'd1, 1'b1, 32'h00000200, 32'h00000000, 14, 32'h1234F00D, 0, 0, 4'b0011, 32'h00000000, 32'h0000F00D};

    step();
    step();
    chk("reset_outputs", |{dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, lsq_decrement,
                           load_result_valid, load_result_tag, load_result_data, busy}, 1'b0);
    reset = 1'b1;

    // Valid, ready head but an empty queue must not start a request.
    e = '0; e.valid = 1'b1; e.ready = 1'b1; e.address = 32'h40; e.size = SZ_WORD;
    lsq[0] = e;
    step(); step(); step();
    chk("empty_stays_idle", {busy, dmem_req}, 2'b00);
    lsq[0].ready = 1'b0;
    lsq_count = 1;
    step(); step();
    chk("not_ready_stays_idle", {busy, dmem_req}, 2'b00);
    lsq[0] = '0;
    lsq_count = 0;

    for (int i = 0; i < 8; i++) begin
      e = '0; e.valid = 1'b1; e.ready = 1'b1;
      e.store = vecs[i].st; e.size = vecs[i].size; e.unsigned_ld = vecs[i].uns;
      e.address = vecs[i].addr; e.data = vecs[i].data; e.tag = vecs[i].tag;
      do_txn(e, vecs[i].gd, vecs[i].rd, vecs[i].rdata, vecs[i].be, vecs[i].wdata, vecs[i].res, t0);
    end

    // Back-to-back loads starting at head 8 and wrapping to 1.
    lsq_head = 8;
    for (int k = 0; k < 3; k++) begin
      e = '0; e.valid = 1'b1; e.ready = 1'b1; e.size = SZ_WORD;
      e.address = 32'h800 + 32'(4 * k); e.tag = 21 + k;
      lsq[(7 + k) % `LSQ_SIZE] = e;
    end
    lsq_count = 3;
    e = lsq[7]; do_txn(e, 0, 0, 32'h11110000, 4'b1111, 32'h0, 32'h11110000, t0);
    chk("b2b_head_wrapped", lsq_head, 1);
    e = lsq[0]; do_txn(e, 0, 0, 32'h11110001, 4'b1111, 32'h0, 32'h11110001, t1);
    e = lsq[1]; do_txn(e, 0, 0, 32'h11110002, 4'b1111, 32'h0, 32'h11110002, t2);
    chk("b2b_gap_1", (t1 - t0) >= 4, 1'b1);
    chk("b2b_gap_2", (t2 - t1) >= 4, 1'b1);

    // Reset asserted while a load waits for its response.
    e = '0; e.valid = 1'b1; e.ready = 1'b1; e.size = SZ_WORD; e.address = 32'h700; e.tag = 50;
    lsq[lsq_head-1] = e; lsq_count = 1;
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("pre_reset_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", |{dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, lsq_decrement,
                                 load_result_valid, load_result_tag, load_result_data, busy}, 1'b0);
    step();
    lsq[lsq_head-1].valid = 1'b0; lsq_count = 0;
    reset = 1'b1;
    step();
    chk("post_reset_idle", busy, 1'b0);

    // Flush while a load is requesting: request drops next cycle.
    dec0 = dec_count; res0 = res_count;
    e.tag = 30; e.address = 32'h500;
    lsq[lsq_head-1] = e; lsq_count = 1;
    step();
    chk("flush_req_pre", dmem_req, 1'b1);
    flush = 1'b1;
    step();
    chk("flush_req_drop", {dmem_req, busy}, 2'b00);
    lsq[lsq_head-1].valid = 1'b0; lsq_count = 0; flush = 1'b0;
    step();

    // Flush while a load waits: response is swallowed.
    e.tag = 31; e.address = 32'h504;
    lsq[lsq_head-1] = e; lsq_count = 1;
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; lsq[lsq_head-1].valid = 1'b0; lsq_count = 0;
    chk("flush_wait_busy", {busy, dmem_req}, 2'b10);
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    step();
    dmem_rvalid = 1'b0;
    chk("flush_wait_idle", {busy, lsq_decrement, load_result_valid}, 3'b000);
    step();
    chk("flush_wait_quiet", {busy, lsq_decrement, load_result_valid}, 3'b000);
    chk("flush_no_dec", dec_count - dec0, 0);
    chk("flush_no_result", res_count - res0, 0);

    // A committed store in WAIT completes despite flush.
    e = '0; e.valid = 1'b1; e.ready = 1'b1; e.store = 1'b1; e.size = SZ_BYTE;
    e.address = 32'h604; e.data = 32'h5A; e.tag = 40;
    lsq[lsq_head-1] = e; lsq_count = 1; rob_commit_valid = 1'b1; rob_commit_tag = 40;
    step();
    rob_commit_valid = 1'b0;
    chk("st_flush_req", {dmem_req, dmem_we, dmem_be, dmem_wdata}, {2'b11, 4'b0001, 32'h0000005A});
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_flush_still_wait", {busy, lsq_decrement}, 2'b10);
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("st_flush_done", {lsq_decrement, load_result_valid}, 2'b10);
    retire();
    step();

    // Randomized transactions against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      sz = $urandom_range(0, 2);
      e = '0; e.valid = 1'b1; e.ready = 1'b1;
      e.store = 1'($urandom_range(0, 1));
      e.unsigned_ld = 1'($urandom_range(0, 1));
      e.size = 2'(sz);
      e.address = $urandom & ~((32'd1 << sz) - 32'd1);
      e.data = $urandom;
      e.tag = $urandom_range(0, 255);
      rd = $urandom;
      lane = int'(e.address[1:0]);
      lsq_head = $urandom_range(1, `LSQ_SIZE);
      do_txn(e, $urandom_range(0, 3), $urandom_range(0, 2), rd, ref_be(sz, lane),
             e.store ? ref_wdata(e.data, lane) : 32'h0, ref_load(rd, lane, sz, e.unsigned_ld), t0);
    end

    step();
    chk("total_decrements", dec_count, exp_decs);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
